// File: rtl/poly_arith_pkg.sv
// -----------------------------------------------------------------------------
// poly_arith_pkg
// Shared constants and types for ML-KEM (FIPS 203) polynomial arithmetic.
//   Q            : ML-KEM prime modulus, 3329
//   Q_INV_NEG    : -Q^-1 mod 2^16, used by the Montgomery reducer
//   MONT_R_MOD_Q : R mod Q with R = 2^16. Multiplying by it converts a
//                  coefficient into the Montgomery domain.
//   MONT_R_INV   : R^-1 mod Q. One Montgomery multiply scales by this.
//   coef_t       : signed 16-bit coefficient
//   prod_t       : signed 32-bit product of two coefficients
// -----------------------------------------------------------------------------
package poly_arith_pkg;

  typedef logic signed [15:0] coef_t;
  typedef logic signed [31:0] prod_t;

  localparam coef_t       Q            = 16'sd3329;
  localparam logic [15:0] Q_INV_NEG    = 16'd3327;
  localparam int          MONT_R_MOD_Q = 2285;
  localparam int          MONT_R_INV   = 169;

  // Move a value in (-Q, Q) into [0, Q-1] with one compare and one add.
  function automatic coef_t cond_add_q(input coef_t t);
    coef_t r;
    r = t;
    if (t[15]) begin
      r = coef_t'(t + Q);
    end
    return r;
  endfunction

endpackage : poly_arith_pkg

// File: rtl/mont_mul_pipe_if.sv
// -----------------------------------------------------------------------------
// mont_mul_pipe_if
// Operand and result streams of the pipelined Montgomery multiplier.
//   in_valid_i / in_ready_o   : operand pair handshake
//   a_i, b_i                  : signed operands
//   tag_i                     : sideband tag travelling with the operand pair
//   out_valid_o / out_ready_i : result handshake
//   res_o, tag_o              : result and its matching tag
// Modports:
//   slave  : the multiplier's view (consumes operands, produces results)
//   master : the environment's view (produces operands, consumes results)
// -----------------------------------------------------------------------------
interface mont_mul_pipe_if #(
  parameter int TAG_W = 8
);
  import poly_arith_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  coef_t            a_i;
  coef_t            b_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  coef_t            res_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  in_valid_i, a_i, b_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, tag_o
  );

  modport master (
    output in_valid_i, a_i, b_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, tag_o
  );

endinterface : mont_mul_pipe_if

// File: rtl/modular_reduce.sv
// -----------------------------------------------------------------------------
// modular_reduce
// Combinational signed Montgomery reduction with R = 2^16.
//   z_i   : signed 32-bit input, |z_i| < Q * 2^15
//   res_o : signed 16-bit t = z_i * R^-1 (mod Q), with |t| < Q
// m is the signed low half of z_i * (-Q^-1). Adding m*Q zeroes the low 16
// bits of the sum exactly, so the shift below divides without rounding.
// Because m is taken as signed, the result stays inside (-Q, Q).
// -----------------------------------------------------------------------------
module modular_reduce
  import poly_arith_pkg::*;
(
  input  prod_t z_i,
  output coef_t res_o
);

  logic [15:0] m_u;
  coef_t       m;
  prod_t       acc;

  // The product is evaluated at 16 bits, which gives z * (-Q^-1) mod 2^16.
  assign m_u   = z_i[15:0] * Q_INV_NEG;
  assign m     = $signed(m_u);
  assign acc   = z_i + prod_t'(m) * prod_t'(Q);
  assign res_o = coef_t'(acc >>> 16);

endmodule : modular_reduce

// File: rtl/mont_mul_pipe.sv
// -----------------------------------------------------------------------------
// mont_mul_pipe
// Three-stage Montgomery coefficient multiplier: res = a*b*R^-1 mod Q.
// It accepts one operand pair per cycle and stalls with a valid/ready
// handshake.
//   S1: p = a*b (32-bit signed) and the tag
//   S2: t = modular_reduce(p) and the tag
//   S3: result (canonical when CANONICAL=1) and the tag; drives res_o/tag_o
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset; clears all state
//   flush_i : clears all stage valid bits at the next edge and drops any
//             word accepted in the same cycle
//   bus     : operand/result streams (mont_mul_pipe_if.slave)
//   busy_o  : OR of the stage valid bits
// Parameters:
//   TAG_W     : tag width; must match the interface instance
//   CANONICAL : 1 -> result in [0,Q-1]; 0 -> raw reducer output in (-Q,Q)
// -----------------------------------------------------------------------------
module mont_mul_pipe
  import poly_arith_pkg::*;
#(
  parameter int TAG_W     = 8,
  parameter bit CANONICAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  mont_mul_pipe_if.slave  bus,
  output logic            busy_o
);

  logic             v1_reg;
  logic             v2_reg;
  logic             v3_reg;
  logic             en1;
  logic             en2;
  logic             en3;

  prod_t            p_reg;
  coef_t            t_reg;
  coef_t            res_reg;
  logic [TAG_W-1:0] tag1_reg;
  logic [TAG_W-1:0] tag2_reg;
  logic [TAG_W-1:0] tag3_reg;

  prod_t            p_next;
  coef_t            t_next;
  coef_t            res_next;

  // A stage may advance when it is empty or when the stage after it advances.
  // This chain makes in_ready_o depend combinationally on out_ready_i. As a
  // result a full pipeline keeps full throughput when the consumer is ready.
  assign en3 = !v3_reg || bus.out_ready_i;
  assign en2 = !v2_reg || en3;
  assign en1 = !v1_reg || en2;

  assign bus.in_ready_o = en1;

  assign p_next = prod_t'(bus.a_i) * prod_t'(bus.b_i);

  modular_reduce u_reduce (
    .z_i   (p_reg),
    .res_o (t_next)
  );

  generate
    if (CANONICAL) begin : g_canon
      assign res_next = cond_add_q(t_reg);
    end else begin : g_raw
      assign res_next = t_reg;
    end
  endgenerate

  // Valid bits. A flush wins over any simultaneous accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else if (flush_i) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      if (en1) v1_reg <= bus.in_valid_i;
      if (en2) v2_reg <= v1_reg;
      if (en3) v3_reg <= v2_reg;
    end
  end

  // Data registers load only when their stage is enabled. They hold while
  // stalled, which keeps res_o/tag_o stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_reg    <= '0;
      tag1_reg <= '0;
      t_reg    <= '0;
      tag2_reg <= '0;
      res_reg  <= '0;
      tag3_reg <= '0;
    end else begin
      if (en1) begin
        p_reg    <= p_next;
        tag1_reg <= bus.tag_i;
      end
      if (en2) begin
        t_reg    <= t_next;
        tag2_reg <= tag1_reg;
      end
      if (en3) begin
        res_reg  <= res_next;
        tag3_reg <= tag2_reg;
      end
    end
  end

  assign bus.out_valid_o = v3_reg;
  assign bus.res_o       = res_reg;
  assign bus.tag_o       = tag3_reg;
  assign busy_o          = v1_reg || v2_reg || v3_reg;

endmodule : mont_mul_pipe

// File: tb/tb_mont_mul_pipe.sv
module tb_mont_mul_pipe;
  import poly_arith_pkg::*;

  localparam int TAG_W = 8;

  typedef struct {
    int          a;
    int          b;
    logic [15:0] exp_res;
  } vec_t;

  typedef struct {
    logic [15:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  logic flush_i = 1'b0;
  logic busy_o;

  mont_mul_pipe_if #(.TAG_W(TAG_W)) bus ();

  mont_mul_pipe #(.TAG_W(TAG_W), .CANONICAL(1'b1)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .bus     (bus),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   out_count = 0;
  int   first_out_cyc = -1;
  int   last_out_cyc = -1;
  exp_t q[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: a*b*R^-1 mod Q, folded into [0, Q-1].
  function automatic logic [15:0] golden(input int a, input int b);
    longint r;
    r = (longint'(a) * longint'(b) * longint'(MONT_R_INV)) % 3329;
    if (r < 0) r += 3329;
    return 16'(r);
  endfunction

  function automatic int rand_coef();
    return int'($urandom_range(6656)) - 3328;
  endfunction

  // Inputs are already set. Record the handshakes that occur at the next
  // rising edge, then advance to the following falling edge.
  task automatic step();
    exp_t e;
    #1;
    if (bus.out_valid_o && bus.out_ready_i) begin
      if (q.size() == 0) begin
        chk("out_without_pending_input", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("res", 32'(bus.res_o), 32'(e.res));
        chk("tag", 32'(bus.tag_o), 32'(e.tag));
        out_count++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
    end
    if (flush_i) begin
      q.delete();
    end else if (bus.in_valid_i && bus.in_ready_o) begin
      e.res = golden(int'(bus.a_i), int'(bus.b_i));
      e.tag = bus.tag_i;
      q.push_back(e);
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic drive(input int a, input int b, input int tag);
    bus.in_valid_i = 1'b1;
    bus.a_i        = 16'(a);
    bus.b_i        = 16'(b);
    bus.tag_i      = TAG_W'(tag);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.in_valid_i = 1'b0;
    while (q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sent;
    int n;
    int stalls;
    bit pend;
    bit acc;
    logic [15:0] hold_res;
    logic [TAG_W-1:0] hold_tag;

    vecs[0]  = '{1,     1,     16'd169};
    vecs[1]  = '{0,     1234,  16'd0};
    vecs[2]  = '{2285,  17,    16'd17};
    vecs[3]  = '{-1,    1,     16'd3160};
    vecs[4]  = '{3328,  3328,  16'd169};
    vecs[5]  = '{-3328, -3328, 16'd169};
    vecs[6]  = '{3328,  -3328, 16'd3160};
    vecs[7]  = '{2285,  2285,  16'd2285};
    vecs[8]  = '{-2285, 17,    16'd3312};
    vecs[9]  = '{3328,  1,     16'd3160};
    vecs[10] = '{2,     3,     16'd1014};
    vecs[11] = '{100,   200,   16'd1065};

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.tag_i       = '0;
    bus.out_ready_i = 1'b1;

    // Reset state
    #2;
    chk("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_res", 32'(bus.res_o), 32'd0);
    chk("reset_tag", 32'(bus.tag_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk_i);

    // Directed vectors: one word at a time, exact 3-cycle latency
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b, i + 16);
      bus.out_ready_i = 1'b1;
      #1;
      chk("vec_in_ready", 32'(bus.in_ready_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      lat = 1;
      while (!bus.out_valid_o && lat < 10) begin
        @(posedge clk_i);
        @(negedge clk_i);
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_res", 32'(bus.res_o), 32'(vecs[i].exp_res));
      chk("vec_tag", 32'(bus.tag_o), 32'(i + 16));
      @(posedge clk_i);
      @(negedge clk_i);
      chk("vec_consumed", 32'(bus.out_valid_o), 32'd0);
    end

    // 256 back-to-back words, tag = index
    out_count = 0;
    first_out_cyc = -1;
    stalls = 0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(rand_coef(), rand_coef(), i);
      #1;
      if (!bus.in_ready_o) stalls++;
      step();
    end
    drain("stream_drain");
    chk("stream_count", 32'(out_count), 32'd256);
    chk("stream_consecutive", 32'(last_out_cyc - first_out_cyc), 32'd255);
    chk("stream_stalls", 32'(stalls), 32'd0);

    // Backpressure: fill three stages, then hold
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_coef(), rand_coef(), 100 + i);
      step();
    end
    drive(77, 88, 103);
    #1;
    chk("bp_in_ready_low", 32'(bus.in_ready_o), 32'd0);
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
    hold_res = bus.res_o;
    hold_tag = bus.tag_o;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_res", 32'(bus.res_o), 32'(hold_res));
      chk("bp_hold_tag", 32'(bus.tag_o), 32'(hold_tag));
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready_o), 32'd1);
    out_count = 0;
    step();
    drain("bp_drain");
    chk("bp_count", 32'(out_count), 32'd4);

    // Randomised valid/ready
    out_count = 0;
    sent = 0;
    n = 0;
    pend = 1'b0;
    bus.in_valid_i = 1'b0;
    while (sent < 10000 && n < 60000) begin
      if (!pend) begin
        if ($urandom_range(9) < 7) begin
          drive(rand_coef(), rand_coef(), sent);
          pend = 1'b1;
        end else begin
          bus.in_valid_i = 1'b0;
        end
      end
      bus.out_ready_i = ($urandom_range(9) < 6);
      #1;
      acc = bus.in_valid_i && bus.in_ready_o;
      step();
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
      n++;
    end
    bus.out_ready_i = 1'b1;
    drain("rand_drain");
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_count", 32'(out_count), 32'd10000);

    // Flush with three words in flight
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_coef(), rand_coef(), 200 + i);
      step();
    end
    bus.in_valid_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd0);

    // Flush wins over a simultaneous accept
    bus.out_ready_i = 1'b1;
    drive(5, 6, 210);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("flush_drop_busy", 32'(busy_o), 32'd0);
    out_count = 0;
    drive(2, 3, 211);
    step();
    drain("flush_next_drain");
    chk("flush_next_count", 32'(out_count), 32'd1);

    // Asynchronous reset mid-stream
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(rand_coef(), rand_coef(), 220 + i);
      step();
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_res", 32'(bus.res_o), 32'd0);
    chk("rst_mid_tag", 32'(bus.tag_o), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready_o), 32'd1);
    q.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    out_count = 0;
    for (int i = 0; i < 20; i++) begin
      drive(rand_coef(), rand_coef(), i);
      step();
    end
    drain("rst_resume_drain");
    chk("rst_resume_count", 32'(out_count), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mont_mul_pipe

// File: doc/mont_mul_pipe.md
Name: mont_mul_pipe

Overview:
- Pipelined Montgomery coefficient multiplier for ML-KEM (FIPS 203) polynomial arithmetic.
- Accepts pairs of signed 16-bit coefficients and forms the 32-bit product.
- Feeds the product through the combinational Montgomery reducer, then canonicalises the result to [0, Q-1].
- Sits between the coefficient memory read port and the NTT/basemul write-back path; valid/ready on both sides, full throughput of 1 result/cycle.

Parameters:
TAG_W, 8, width of sideband tag (coefficient index) carried alongside each operand pair
CANONICAL, 1, 1: output in [0,Q-1]; 0: output the raw signed reducer result in (-Q,Q)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous clear of all pipeline valid bits
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  block can accept operand pair this cycle
a_i  in  16  signed operand a, contract |a| <= Q-1
b_i  in  16  signed operand b, contract |b| <= Q-1
tag_i  in  TAG_W  sideband tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
res_o  out  16  a*b*R^-1 mod Q, with R=2^16 (R^-1 = 169 mod Q)
tag_o  out  TAG_W  tag matching res_o
busy_o  out  1  OR of all stage valid bits

Behaviour:
- Reset: one clock, clk_i; rst_n_i is asynchronous and active-low.
  - Asserting rst_n_i clears v1/v2/v3, so out_valid_o=0 and busy_o=0.
  - On reset, res_o=0 and tag_o=0; data registers also reset to 0.
  - in_ready_o=1 immediately after deassertion.
  - Reset mid-operation discards all in-flight data; no partial output.
- Stages, each with its own valid bit:
  - S1: registers p = a_i*b_i (32-bit signed) and the tag.
  - S2: registers t = modular_reduce(p), 16-bit signed, and the tag.
  - S3: registers the result and the tag; drives res_o/tag_o.
  - S3 canonicalisation (CANONICAL=1): t<0 -> t+Q, else t. Input contract gives |p| < Q^2 < Q*2^15, hence |t| < Q.
- Latency: exactly 3 cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o when out_ready_i is held high.
- Stall rules, per-stage enables:
  - en3 = !v3 | out_ready_i
  - en2 = !v2 | en3
  - en1 = !v1 | en2
  - in_ready_o = en1
- No combinational path from in_valid_i to out_valid_o. in_ready_o depends combinationally on out_ready_i; this is permitted.
- A stage loads data only when its enable is high.
  - Its valid bit takes the upstream valid when enabled; otherwise it holds.
  - Data is held stable while out_valid_o=1 and out_ready_i=0 (AXI-style, no drop, no duplicate).
- Full pipeline (v1=v2=v3=1) with out_ready_i=0: in_ready_o=0.
  - Same cycle out_ready_i rises: in_ready_o=1, and all stages shift at the edge.
- flush_i=1 clears all valid bits at the next edge and overrides a simultaneous accept; the accepted word is dropped. Data registers are don't-care.
- Order is strictly preserved; tag_o always pairs with its own res_o.
- Operands outside the contract give undefined res_o. No error flag.

Decomposition:
- poly_arith_pkg (existing) already provides Q and Q_INV_NEG.
- Add to poly_arith_pkg: MONT_R_MOD_Q = 2285 and MONT_R_INV = 169, for benches and the to-Montgomery conversion.
- Sub-module: instantiate the existing modular_reduce between S1 and S2 (z_i = p, res_o = t). Do not re-implement the reduction.
- Canonicalisation stays inline; a single compare/add.

Test Plan:
- Basic: a=1, b=1 with out_ready_i=1 -> res_o=169 on cycle 3 after accept; a=0, b=1234 -> 0.
- Conversion: a=2285, b=17 -> 17. a=-1, b=1 -> 3160 (CANONICAL=1) or -169 (CANONICAL=0). a=3328, b=3328 -> 169.
- Throughput and ordering: stream 256 back-to-back pairs, tag=index, out_ready_i=1 -> 256 results on consecutive cycles, tags 0..255 in order, each matching the golden model.
- Backpressure:
  - Hold out_ready_i=0 after 3 accepts -> in_ready_o=0, res_o/tag_o stable, busy_o=1.
  - Release out_ready_i -> no loss or duplication.
  - Randomised ready/valid over 10,000 vectors -> scoreboard clean.
- Flush/reset:
  - flush_i with 3 words in flight -> out_valid_o=0 next cycle, busy_o=0, the next accepted word is output correctly.
  - rst_n_i low mid-stream -> outputs at reset values asynchronously; streaming resumes correctly after release.
